md5_hash_engine: RTL and testbench
==================================

Name: md5_hash_engine

Overview:
- Parametrised, multi-block successor to the single-block hash generator.
- Computes the full MD5 compression over 1 to 2^BLK_W pre-padded 512-bit blocks, chaining intermediate digests between blocks.
- Reads message words from an external asynchronous-read message memory.
- Returns the 128-bit digest two ways: as a held parallel vector, and as a word-serial stream of four 32-bit words on hashResult.

Parameters:
- BLK_W, 2: width of the block index; up to 2^BLK_W blocks per message.
- ADDR_W, BLK_W+4: message memory word address width, {block, word}.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- numBlocksM1  in  BLK_W  number of blocks minus 1; sampled with start.
- messageIn  in  32  word M[g] of the current block; valid in the same cycle as the address.
- messageAddress  out  ADDR_W  {blk, g}.
- messageRead  out  1  high during ROUND cycles.
- busy  out  1  high in every state except IDLE.
- hashResult  out  32  word-serial digest output.
- dataOutValid  out  1  high while hashResult carries a digest word.
- hashFull  out  128  {A,B,C,D} final chaining value; held until the next start is accepted.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, j = 0, blk = 0.
  - Chaining and working registers = IV: A=0x67452301, B=0xefcdab89, C=0x98badcfe, D=0x10325476.
  - hashFull = IV concatenation.
  - hashResult = 0, dataOutValid = 0, messageRead = 0, busy = 0.
  - Reset asserted mid-operation aborts immediately; no partial digest is output.
- States: IDLE, ROUND, ACCUM, OUT.
- IDLE:
  - On start=1: latch numBlocksM1, set blk=0, j=0, load the chaining registers with IV, load the working registers with IV, go to ROUND.
  - Working registers are copied from IV (the fixed constants), not from the chaining registers, so the copy is correct in the same cycle the chaining registers reload.
- ROUND (one MD5 step per cycle, j = 0..63):
  - Group 0, j<16: F=(B&C)|(~B&D), g=j.
  - Group 1, j<32: F=(D&B)|(~D&C), g=(5j+1) mod 16.
  - Group 2, j<48: F=B^C^D, g=(3j+5) mod 16.
  - Group 3, otherwise: F=C^(B|~D), g=7j mod 16.
  - Shift s = table[group][j mod 4]:
    - group 0: {7,12,17,22}
    - group 1: {5,9,14,20}
    - group 2: {4,11,16,23}
    - group 3: {6,10,15,21}
  - K[j] = floor(2^32·|sin(j+1)|), stored as a 64-entry constant ROM.
  - Register update: A<=D, D<=C, C<=B, B<=B+rotl32(A+F+K[j]+messageIn, s).
  - All additions are mod 2^32.
  - messageAddress={blk,g}, messageRead=1.
  - j==63 → ACCUM; otherwise j<=j+1.
- ACCUM (1 cycle):
  - Each chaining register += its working register, mod 2^32.
  - If blk < numBlocksM1: blk<=blk+1, j<=0, working<=new chaining sum, go to ROUND.
  - Otherwise: hashFull<={new A,B,C,D}, output word counter<=0, go to OUT.
- OUT (4 cycles):
  - dataOutValid=1; hashResult = A, B, C, D on successive cycles.
  - Then return to IDLE with dataOutValid=0.
  - hashFull stays held.
- Latency:
  - Start accepted at edge E0; the first output word (A) is valid in the cycle after edge E0+65·N, for N blocks.
  - Last word is valid 3 cycles later.
  - Single block: 65 edges to first word, 69 edges until busy falls.
- start while busy: ignored, no effect on the state or the latched count.
- start held high in IDLE at the end of OUT: a new run starts on the first IDLE cycle.
- messageAddress and messageRead are 0 outside ROUND.

Test Plan:
1. Reset mid-run: assert rst low during ROUND, j≈30, numBlocksM1=0 → all outputs return to their reset values immediately. After release with start=1, a fresh run produces the correct empty-string digest below.
2. Empty message, 1 block (M0=0x00000080, M1..M15=0, numBlocksM1=0) → hashResult sequence 0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec with dataOutValid=1. First word appears 65 edges after start; hashFull equals the concatenation.
3. "abc", 1 block (M0=0x80636261, M14=0x00000018, others 0) → words 0x98500190, 0xb04fd23c, 0x7d3f96d6, 0x727fe128.
4. Two-block message (a 64-byte string of 'a', standard padding in block 1, numBlocksM1=1) → digest matches the software MD5 model. messageAddress upper bit toggles to 1 exactly at edge 65; first word appears 130 edges after start.
5. Address pattern: monitor messageAddress over one block → g sequence 0..15, then 1,6,11,0,…, then 5,8,11,14,…, then 0,7,14,5,…. messageRead is high for exactly 64 cycles per block.
6. start pulsed during ROUND and during OUT → ignored: same digest, same timing, no second run. Back-to-back start held high → a second run begins in the IDLE cycle after the last word.

Source files
------------

// File: rtl/md5_hash_engine.sv
// md5_hash_engine: multi-block MD5 compression, one step per cycle,
// digest returned as a held vector and as a 4-word stream.
module md5_hash_engine #(
  parameter int BLK_W  = 2,
  parameter int ADDR_W = BLK_W + 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BLK_W-1:0]  numBlocksM1,
  input  logic [31:0]       messageIn,
  output logic [ADDR_W-1:0] messageAddress,
  output logic              messageRead,
  output logic              busy,
  output logic [31:0]       hashResult,
  output logic              dataOutValid,
  output logic [127:0]      hashFull
);

  typedef enum logic [1:0] {
    S_IDLE, S_ROUND, S_ACCUM, S_OUT
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [4:0] SH [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  state_t state_q, state_d;
  logic [5:0] j;
  logic [BLK_W-1:0] blk, nbm1;
  logic [1:0] cnt;
  logic [31:0] a, b, c, d;
  logic [31:0] ha, hb, hc, hd;
  logic [127:0] full_q;

  logic [31:0] f, t;
  logic [3:0] g;
  logic [4:0] s;
  logic [63:0] rot;
  logic [31:0] sa, sb, sc, sd;

  always_comb begin
    f = 32'h0;
    g = 4'h0;
    unique case (j[5:4])
      2'd0: begin
        f = (b & c) | (~b & d);
        g = j[3:0];
      end
      2'd1: begin
        f = (d & b) | (~d & c);
        g = j[3:0] * 4'd5 + 4'd1;
      end
      2'd2: begin
        f = b ^ c ^ d;
        g = j[3:0] * 4'd3 + 4'd5;
      end
      default: begin
        f = c ^ (b | ~d);
        g = j[3:0] * 4'd7;
      end
    endcase
  end

  // Rotate by taking the upper half of a doubled word shifted left.
  assign s   = SH[{j[5:4], j[1:0]}];
  assign t   = a + f + K[j] + messageIn;
  assign rot = {t, t} << s;

  assign sa = ha + a;
  assign sb = hb + b;
  assign sc = hc + c;
  assign sd = hd + d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      j       <= '0;
      blk     <= '0;
      nbm1    <= '0;
      cnt     <= '0;
      a  <= IV_A; b  <= IV_B; c  <= IV_C; d  <= IV_D;
      ha <= IV_A; hb <= IV_B; hc <= IV_C; hd <= IV_D;
      full_q  <= {IV_A, IV_B, IV_C, IV_D};
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            nbm1 <= numBlocksM1;
            blk  <= '0;
            j    <= '0;
            a  <= IV_A; b  <= IV_B; c  <= IV_C; d  <= IV_D;
            ha <= IV_A; hb <= IV_B; hc <= IV_C; hd <= IV_D;
          end
        end
        S_ROUND: begin
          a <= d;
          d <= c;
          c <= b;
          b <= b + rot[63:32];
          if (j != 6'd63) j <= j + 6'd1;
        end
        S_ACCUM: begin
          ha <= sa; hb <= sb; hc <= sc; hd <= sd;
          if (blk < nbm1) begin
            blk <= blk + 1'b1;
            j   <= '0;
            a <= sa; b <= sb; c <= sc; d <= sd;
          end else begin
            full_q <= {sa, sb, sc, sd};
            cnt    <= '0;
          end
        end
        default: cnt <= cnt + 2'd1;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    busy           = 1'b1;
    messageRead    = 1'b0;
    messageAddress = '0;
    dataOutValid   = 1'b0;
    hashResult     = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_ROUND;
      end
      S_ROUND: begin
        messageRead    = 1'b1;
        messageAddress = ADDR_W'({blk, g});
        if (j == 6'd63) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        state_d = (blk < nbm1) ? S_ROUND : S_OUT;
      end
      default: begin
        dataOutValid = 1'b1;
        unique case (cnt)
          2'd0:    hashResult = ha;
          2'd1:    hashResult = hb;
          2'd2:    hashResult = hc;
          default: hashResult = hd;
        endcase
        if (cnt == 2'd3) state_d = S_IDLE;
      end
    endcase
  end

  assign hashFull = full_q;

endmodule

// File: tb/tb_md5_hash_engine.sv
// Bench for md5_hash_engine: known digests plus random
// multi-block messages against a procedural MD5 model.
module tb_md5_hash_engine;

  localparam int BLK_W  = 2;
  localparam int ADDR_W = 6;
  localparam logic [127:0] IV = {
    32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476
  };
  localparam logic [127:0] EMPTY_D = {
    32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec
  };
  localparam logic [127:0] ABC_D = {
    32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [BLK_W-1:0] nbm1 = '0;
  logic [31:0] msg_in;
  logic [ADDR_W-1:0] addr;
  logic rd, busy, valid;
  logic [31:0] hres;
  logic [127:0] hfull;

  logic [31:0] mem [64];
  assign msg_in = mem[addr];

  md5_hash_engine #(.BLK_W(BLK_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .numBlocksM1(nbm1),
    .messageIn(msg_in),
    .messageAddress(addr),
    .messageRead(rd),
    .busy(busy),
    .hashResult(hres),
    .dataOutValid(valid),
    .hashFull(hfull)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  logic [31:0] kt [64];
  int sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20,
                  4, 11, 16, 23, 6, 10, 15, 21};

  logic [31:0] got_w [4];
  int got_lat, blk1_e, reads;
  logic [ADDR_W-1:0] addr_q [$];

  function automatic void init_k();
    for (int i = 0; i < 64; i++) begin
      real v;
      v = $sin(real'(i + 1));
      if (v < 0.0) v = -v;
      kt[i] = 32'(longint'($floor(v * 4294967296.0)));
    end
  endfunction

  function automatic logic [127:0] md5_model(input int nb);
    logic [31:0] h [4];
    logic [31:0] a, b, c, d, f, t, r;
    int g, s;
    h[0] = IV[127:96]; h[1] = IV[95:64];
    h[2] = IV[63:32];  h[3] = IV[31:0];
    for (int k = 0; k < nb; k++) begin
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      for (int i = 0; i < 64; i++) begin
        if (i < 16) begin
          f = (b & c) | (~b & d); g = i;
        end else if (i < 32) begin
          f = (d & b) | (~d & c); g = (5 * i + 1) % 16;
        end else if (i < 48) begin
          f = b ^ c ^ d; g = (3 * i + 5) % 16;
        end else begin
          f = c ^ (b | ~d); g = (7 * i) % 16;
        end
        s = sh[(i / 16) * 4 + i % 4];
        t = a + f + kt[i] + mem[k * 16 + g];
        r = (t << s) | (t >> (32 - s));
        a = d; d = c; c = b; b = b + r;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
    end
    return {h[0], h[1], h[2], h[3]};
  endfunction

  function automatic int exp_g(input int i);
    if (i < 16) return i;
    if (i < 32) return (5 * i + 1) % 16;
    if (i < 48) return (3 * i + 5) % 16;
    return (7 * i) % 16;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  // Starts a run and captures the four output words. Returns one
  // edge after the last word, with the engine back in IDLE.
  task automatic run(input int n, input bit p_round,
                     input bit p_out, input bit hold);
    int e;
    int widx;
    e = 0;
    widx = 0;
    got_lat = -1;
    blk1_e = -1;
    reads = 0;
    addr_q.delete();
    @(negedge clk);
    start = 1'b1;
    nbm1 = n[BLK_W-1:0];
    @(posedge clk); #1;
    while (widx < 4 && e < 600) begin
      if (!hold) start = 1'b0;
      if (rd) begin
        reads++;
        addr_q.push_back(addr);
        if (blk1_e < 0 && addr[5:4] == 2'd1) blk1_e = e;
      end
      if (valid) begin
        if (widx == 0) got_lat = e;
        got_w[widx] = hres;
        widx++;
      end
      if (p_round && e == 20) begin
        start = 1'b1; nbm1 = 2'd3;
      end
      if (p_out && widx == 1 && got_lat == e) begin
        start = 1'b1; nbm1 = 2'd3;
      end
      if (widx < 4) begin
        @(posedge clk); #1;
        e++;
      end
    end
    tests++;
    if (widx < 4) begin
      failed++;
      $display("FAIL run_timeout words=%0d required=4", widx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      failed++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    tests++;
    if (rd !== 1'b0) begin
      failed++; $display("FAIL reset_read got=%b exp=0", rd);
    end
    tests++;
    if (valid !== 1'b0) begin
      failed++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
    tests++;
    if (hres !== 32'h0) begin
      failed++; $display("FAIL reset_result got=%h exp=0", hres);
    end
    tests++;
    if (hfull !== IV) begin
      failed++; $display("FAIL reset_full got=%h exp=%h", hfull, IV);
    end
    tests++;
    if (addr !== '0) begin
      failed++; $display("FAIL reset_addr got=%h exp=0", addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_empty();
    logic [127:0] got;
    clear_mem();
    mem[0] = 32'h00000080;
    run(0, 1'b0, 1'b0, 1'b0);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== EMPTY_D) begin
      failed++; $display("FAIL empty_digest got=%h exp=%h", got, EMPTY_D);
    end
    tests++;
    if (md5_model(1) !== EMPTY_D) begin
      failed++;
      $display("FAIL empty_model got=%h exp=%h", md5_model(1), EMPTY_D);
    end
    tests++;
    if (got_lat != 65) begin
      failed++; $display("FAIL empty_latency got=%0d exp=65", got_lat);
    end
    tests++;
    if (hfull !== EMPTY_D) begin
      failed++; $display("FAIL empty_full got=%h exp=%h", hfull, EMPTY_D);
    end
  endtask

  task automatic test_abc();
    logic [127:0] got;
    clear_mem();
    mem[0] = 32'h80636261;
    mem[14] = 32'h00000018;
    run(0, 1'b0, 1'b0, 1'b0);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== ABC_D) begin
      failed++; $display("FAIL abc_digest got=%h exp=%h", got, ABC_D);
    end
    tests++;
    if (hfull !== ABC_D) begin
      failed++; $display("FAIL abc_full got=%h exp=%h", hfull, ABC_D);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    clear_mem();
    mem[0] = 32'h00000080;
    @(negedge clk);
    start = 1'b1;
    nbm1 = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || rd !== 1'b0 || valid !== 1'b0) begin
      failed++;
      $display("FAIL midrst_ctrl got=%b%b%b exp=000", busy, rd, valid);
    end
    tests++;
    if (hfull !== IV || hres !== 32'h0 || addr !== '0) begin
      failed++;
      $display("FAIL midrst_data full=%h res=%h addr=%h exp=%h/0/0",
               hfull, hres, addr, IV);
    end
    @(negedge clk);
    rst = 1'b1;
    run(0, 1'b0, 1'b0, 1'b0);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== EMPTY_D) begin
      failed++; $display("FAIL midrst_digest got=%h exp=%h", got, EMPTY_D);
    end
  endtask

  task automatic test_two_block();
    logic [127:0] got, exp;
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h61616161;
    mem[16] = 32'h00000080;
    mem[30] = 32'h00000200;
    exp = md5_model(2);
    run(1, 1'b0, 1'b0, 1'b0);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== exp) begin
      failed++; $display("FAIL two_digest got=%h exp=%h", got, exp);
    end
    tests++;
    if (got_lat != 130) begin
      failed++; $display("FAIL two_latency got=%0d exp=130", got_lat);
    end
    tests++;
    if (blk1_e != 65) begin
      failed++; $display("FAIL two_blk1_edge got=%0d exp=65", blk1_e);
    end
    tests++;
    if (reads != 128) begin
      failed++; $display("FAIL two_reads got=%0d exp=128", reads);
    end
  endtask

  task automatic test_addr_pattern();
    int bad;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    run(0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (reads != 64) begin
      failed++; $display("FAIL addr_reads got=%0d exp=64", reads);
    end
    bad = 0;
    for (int i = 0; i < 64 && i < addr_q.size(); i++)
      if (int'(addr_q[i]) != exp_g(i)) bad++;
    tests++;
    if (bad != 0 || addr_q.size() != 64) begin
      failed++;
      $display("FAIL addr_seq got=%0d wrong of %0d exp=0 of 64",
               bad, addr_q.size());
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] got;
    int extra;
    clear_mem();
    mem[0] = 32'h00000080;
    run(0, 1'b1, 1'b1, 1'b0);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== EMPTY_D) begin
      failed++; $display("FAIL ign_digest got=%h exp=%h", got, EMPTY_D);
    end
    tests++;
    if (got_lat != 65) begin
      failed++; $display("FAIL ign_latency got=%0d exp=65", got_lat);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) extra++;
      @(posedge clk); #1;
    end
    tests++;
    if (extra != 0) begin
      failed++; $display("FAIL ign_rerun busy_cycles=%0d exp=0", extra);
    end
  endtask

  task automatic test_random();
    logic [127:0] got, exp;
    int n;
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      exp = md5_model(n + 1);
      run(n, 1'b0, 1'b0, 1'b0);
      got = {got_w[0], got_w[1], got_w[2], got_w[3]};
      tests++;
      if (got !== exp || hfull !== exp) begin
        failed++;
        $display("FAIL rand_digest n=%0d got=%h full=%h exp=%h",
                 n + 1, got, hfull, exp);
      end
      tests++;
      if (got_lat != 65 * (n + 1)) begin
        failed++;
        $display("FAIL rand_latency got=%0d exp=%0d",
                 got_lat, 65 * (n + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got;
    int e;
    clear_mem();
    mem[0] = 32'h00000080;
    run(0, 1'b0, 1'b0, 1'b1);
    got = {got_w[0], got_w[1], got_w[2], got_w[3]};
    tests++;
    if (got !== EMPTY_D) begin
      failed++; $display("FAIL b2b_digest got=%h exp=%h", got, EMPTY_D);
    end
    tests++;
    if (busy !== 1'b0) begin
      failed++; $display("FAIL b2b_idle busy=%b exp=0", busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || rd !== 1'b1 || addr !== '0) begin
      failed++;
      $display("FAIL b2b_restart busy=%b rd=%b addr=%h exp=1/1/0",
               busy, rd, addr);
    end
    e = 0;
    while (!valid && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    tests++;
    if (e != 65 || hres !== EMPTY_D[127:96]) begin
      failed++;
      $display("FAIL b2b_second lat=%0d word=%h exp=65/%h",
               e, hres, EMPTY_D[127:96]);
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    init_k();
    clear_mem();
    test_reset();
    test_empty();
    test_abc();
    test_reset_mid();
    test_two_block();
    test_addr_pattern();
    test_ignored_start();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
